instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- PC-generation and fetch-buffer stage directly upstream of the combinational instruction memory and downstream-feeding the decode stage.
- Drives a word-aligned byte address to the instruction memory and captures the returned 32-bit word the same cycle into a small FIFO.
- Presents {pc, inst} pairs to decode over a valid/ready handshake.
- Branch/jump redirects from execute flush the buffer and restart fetch at the new target.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MEM_BYTES, 1024, instruction memory size in bytes; fetch halts at PC >= MEM_BYTES.
- DEPTH, 4, fetch-queue entries (power of two, >= 2).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  fetch permitted when high.
- imem_pc  output  32  address to instruction memory.
- imem_inst  input  32  instruction word read combinationally at imem_pc.
- if_valid  output  1  queue head valid toward decode.
- if_inst  output  32  queue head instruction.
- if_pc  output  32  queue head PC.
- id_ready  input  1  decode accepts head this cycle.
- redirect_valid  input  1  flush and redirect request.
- redirect_pc  input  32  redirect target.
- halted  output  1  state == HALT.
- fetch_count  output  32  number of words enqueued since reset; saturates at all-ones.

Behaviour:
- Reset is asynchronous, active-low, on the single clock domain. Reset values: pc=RESET_PC, count=0, read/write pointers=0, state=IDLE, fetch_count=0, halted=0, if_valid=0.
- imem_pc = pc register, combinational, always driven.
- States:
  - IDLE: no enqueue. Go to RUN when fetch_en=1.
  - RUN: enqueue allowed. Go to IDLE when fetch_en=0. Go to HALT when the next pc >= MEM_BYTES.
  - HALT: no enqueue; queue still drains. Leaves only on redirect.
- Enqueue in RUN when fetch_en=1, pc < MEM_BYTES, redirect_valid=0, and either count < DEPTH or a dequeue occurs the same cycle.
  - On enqueue: write {pc, imem_inst} at the write pointer, pc <= pc+4, fetch_count++.
- Dequeue when if_valid && id_ready. if_valid = (count != 0) && !redirect_valid.
- Head outputs come straight from the queue (no extra register). if_inst/if_pc hold stable while if_valid=1 and id_ready=0.
- Enqueue and dequeue in the same cycle: count unchanged. A full queue with dequeue still accepts the new word (no bubble).
- Full queue without dequeue: pc holds and imem_pc is re-presented next cycle.
- Redirect (highest priority, any state):
  - count<=0 and pointers reset; no enqueue and no dequeue that cycle.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - state <= RUN if fetch_en else IDLE, even if the target >= MEM_BYTES; HALT is then entered the next cycle with no enqueue.
- Fetch latency: a word at pc is visible on if_inst the cycle after imem_pc = pc, provided the queue was empty.
- Pointers wrap modulo DEPTH. pc+4 wraps modulo 2^32; the wrapped value is caught by the MEM_BYTES check.
- fetch_en deasserted mid-stream: words already queued remain and drain normally.
- Reset asserted mid-operation: all state clears immediately, regardless of clk.

Test Plan:
- Reset, then fetch_en=1, id_ready=1, memory model returns 32'hA000_0000|pc -> if_pc = 0,4,8,12 on consecutive cycles; if_inst = A0000000, A0000004, ...; fetch_count increments by 1 each cycle.
- id_ready=0 for 6 cycles -> exactly 4 entries accepted; imem_pc stalls at 16; head stays pc=0. Release id_ready -> pc 0,4,8,12,16 dequeued with no gap or duplicate.
- redirect_valid one cycle with redirect_pc=0x26 while queue holds 3 entries -> if_valid=0 that cycle; queue empty; next head pc=0x24, inst A0000024.
- Run from 0 with MEM_BYTES=1024 -> last enqueued pc=0x3FC; halted=1; fetch_count=256. Queue drains. Redirect to 0x10 -> resumes at 0x10, halted=0.
- fetch_en toggled low for 3 cycles mid-stream -> no enqueue; pc frozen; queued entries drain; resumes at the same pc.
- reset_n pulsed low asynchronously between edges with a full queue -> if_valid drops immediately; after release first if_pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC generator and fetch queue sitting between a combinational
//               instruction memory and the decode stage. Words are captured
//               in the cycle their address is presented and handed to decode
//               as {pc, inst} pairs over a valid/ready handshake. Redirects
//               from execute flush the queue and restart fetch at the target.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 1024,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam int                 c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]        c_MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [c_PTR_W:0]   c_DEPTH     = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE   = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_halted;
    logic [31:0]          r_pc;
    logic [31:0]          r_fetch_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [31:0]          r_q_pc   [DEPTH];
    logic [31:0]          r_q_inst [DEPTH];

    logic                 w_valid;
    logic                 w_deq;
    logic                 w_enq;
    logic                 w_pc_in_range;
    logic [31:0]          w_pc_next;
    logic                 w_unused_low_bits;

    // Redirect targets are forced word aligned, so the low bits never matter.
    assign w_unused_low_bits = ^redirect_pc[1:0];

    // A pending redirect hides the head so decode never consumes a flushed word.
    assign w_valid       = (r_count != '0) && !redirect_valid;
    assign w_deq         = w_valid && id_ready;
    assign w_pc_in_range = (r_pc < c_MEM_LIMIT);
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign w_enq         = (r_state == S_RUN) && fetch_en && w_pc_in_range &&
                           !redirect_valid && ((r_count < c_DEPTH) || w_deq);
    assign w_pc_next     = w_enq ? (r_pc + 32'd4) : r_pc;

    // Sequencer: PC, queue pointers/occupancy, fetch counter and fetch FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_halted      <= 1'b0;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            // Out-of-range targets still enter RUN; HALT follows one cycle later.
            r_state  <= fetch_en ? S_RUN : S_IDLE;
            r_halted <= 1'b0;
            r_pc     <= {redirect_pc[31:2], 2'b00};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (r_fetch_count != '1) begin
                    r_fetch_count <= r_fetch_count + 32'd1;
                end
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - c_CNT_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (fetch_en) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!fetch_en) begin
                        r_state <= S_IDLE;
                    end else if (w_pc_next >= c_MEM_LIMIT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Queue storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_pc[r_wr_ptr]   <= r_pc;
            r_q_inst[r_wr_ptr] <= imem_inst;
        end
    end

    assign imem_pc     = r_pc;
    assign if_valid    = w_valid;
    assign if_pc       = r_q_pc[r_rd_ptr];
    assign if_inst     = r_q_inst[r_rd_ptr];
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Scoreboard bench for instr_fetch_unit. Memory returns
//               32'hA000_0000 | address; the expected in-order PC stream is
//               queued when stimulus is applied and popped on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
    localparam int          c_MEM_BYTES = 1024;
    localparam int          c_DEPTH     = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [31:0] fetch_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb [$];
    logic [31:0] last_pc = 32'hFFFF_FFFF;
    logic        got;

    instr_fetch_unit #(
        .RESET_PC  (c_RESET_PC),
        .MEM_BYTES (c_MEM_BYTES),
        .DEPTH     (c_DEPTH)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory model: word content encodes its own address.
    assign imem_inst = 32'hA000_0000 | imem_pc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic push_range(input int unsigned first, input int unsigned last);
        for (int unsigned a = first; a <= last; a += 4) begin
            sb.push_back(32'(a));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake monitor: inputs are stable from posedge+1, so the negedge view
    // is exactly what the DUT acts on at the next rising edge.
    always @(negedge clk) begin
        if (reset_n && if_valid && id_ready) begin
            if (sb.size() == 0) begin
                check_eq("deq_unexpected_pc", if_pc, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                check_eq("deq_pc", if_pc, e);
                check_eq("deq_inst", if_inst, 32'hA000_0000 | e);
                last_pc = if_pc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'h0, if_valid}, 32'd0);
        check_eq("rst_halted", {31'h0, halted}, 32'd0);
        check_eq("rst_fcount", fetch_count, 32'd0);
        check_eq("rst_imem_pc", imem_pc, c_RESET_PC);

        // Streaming fetch with decode always ready.
        push_range(0, 32'hFC);
        reset_n  = 1'b1;
        fetch_en = 1'b1;
        id_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("stream_fcount", fetch_count, 32'(i + 1));
            check_eq("stream_valid", {31'h0, if_valid}, 32'd1);
        end

        // Restart at 0 with decode stalled: queue fills to DEPTH and pc stalls.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        sb.delete();
        push_range(0, 32'hFC);
        step();
        redirect_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("stall_fcount", fetch_count, 32'd13);
        check_eq("stall_imem_pc", imem_pc, 32'd16);
        check_eq("stall_head_pc", if_pc, 32'd0);
        check_eq("stall_head_inst", if_inst, 32'hA000_0000);
        check_eq("stall_valid", {31'h0, if_valid}, 32'd1);
        step();
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("drain_no_gap", {31'h0, if_valid}, 32'd1);
        end

        // Redirect to an unaligned target while the queue holds entries.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h26;
        sb.delete();
        push_range(32'h24, 32'h3FC);
        @(negedge clk);
        check_eq("redir_valid_low", {31'h0, if_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("redir_head_valid", {31'h0, if_valid}, 32'd1);
        check_eq("redir_head_pc", if_pc, 32'h24);
        check_eq("redir_head_inst", if_inst, 32'hA000_0024);

        // Fresh run from reset to the end of memory.
        step();
        reset_n = 1'b0;
        sb.delete();
        step();
        reset_n = 1'b1;
        push_range(0, 32'h3FC);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (halted) got = 1'b1;
        end
        check_eq("halt_reached", {31'h0, got}, 32'd1);
        check_eq("halt_fcount", fetch_count, 32'd256);
        check_eq("halt_imem_pc", imem_pc, 32'h400);
        repeat (6) @(negedge clk);
        check_eq("halt_sb_left", 32'(sb.size()), 32'd0);
        check_eq("halt_last_pc", last_pc, 32'h3FC);
        check_eq("halt_drained", {31'h0, if_valid}, 32'd0);
        check_eq("halt_held", {31'h0, halted}, 32'd1);

        // Redirect out of HALT.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        sb.delete();
        push_range(32'h10, 32'h3FC);
        step();
        redirect_valid = 1'b0;
        check_eq("resume_halted", {31'h0, halted}, 32'd0);

        // fetch_en low for three cycles mid-stream.
        repeat (3) @(posedge clk);
        #1;
        fetch_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("pause_imem_pc", imem_pc, 32'h1C);
        check_eq("pause_drained", {31'h0, if_valid}, 32'd0);
        step();
        fetch_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (if_valid) got = 1'b1;
        end
        check_eq("pause_resume_seen", {31'h0, got}, 32'd1);
        check_eq("pause_resume_pc", if_pc, 32'h1C);

        // Fill the queue, then reset asynchronously between edges.
        step();
        id_ready = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("full_valid", {31'h0, if_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check_eq("async_valid", {31'h0, if_valid}, 32'd0);
        check_eq("async_fcount", fetch_count, 32'd0);
        check_eq("async_imem_pc", imem_pc, c_RESET_PC);
        step();
        reset_n  = 1'b1;
        id_ready = 1'b1;
        push_range(0, 32'hFC);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (if_valid) got = 1'b1;
        end
        check_eq("post_rst_seen", {31'h0, got}, 32'd1);
        check_eq("post_rst_pc", if_pc, c_RESET_PC);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
